memwb_reg: RTL and testbench
============================

# memwb_reg

Dual-issue MEM/WB pipeline register with stall, flush and a load-data hold buffer. Sits between mem_stage and wb_stage: it captures both issue slots' MEM results on each advancing edge and presents them to wb_stage as `wb_*` signals. Memory loads occupy slot 0 only. The data RAM has a synchronous read, so its output arrives during the WB cycle. When WB stalls, that output can change, so this block captures it and supplies a stable `dm_o`.

## Interface
- `HOLD_EN`, 1, enables the load-data hold buffer; 0 passes `dm_rdata` straight through.
- `cpu_clk_50M`  in  1  system clock, rising edge.
- `sys_rst_n`  in  1  asynchronous active-low reset.
- `flush`  in  1  clears both slots (exception or branch squash).
- `stall_mem`  in  1  MEM stage stalled; a bubble enters WB unless WB is also stalled.
- `stall_wb`  in  1  WB stage stalled; hold all registers.
- `mem{0,1}_valid`  in  1  slot carries a real instruction.
- `mem{0,1}_memtype`  in  8  load/store type (bit0/bit2 = signed load).
- `mem{0,1}_mreg`  in  1  result comes from memory.
- `mem{0,1}_whilo`  in  2  HI/LO write enables.
- `mem{0,1}_wreg`  in  1  GPR write enable.
- `mem{0,1}_dre`  in  4  byte read enables.
- `mem{0,1}_wa`  in  5  destination register.
- `mem{0,1}_hilo`  in  64  HI/LO result.
- `mem{0,1}_dreg`  in  32  ALU result.
- `mem{0,1}_is_mthilo`  in  2  01 = MTLO, 10 = MTHI.
- `mem{0,1}_daddr`  in  32  data address.
- `dm_rdata`  in  32  synchronous data-RAM read data.
- `wb{0,1}_*`  out  (same widths as the matching `mem{0,1}_*` input)  registered copy of every `mem{0,1}_*` field, including valid.
- `dm_o`  out  32  load data presented to wb_stage slot 0.
- `hold_active`  out  1  hold buffer is driving `dm_o`.

## Operation
- Register update, evaluated per rising edge in this priority order:
  1. **flush:** all `wb*` fields go to 0.
  2. **stall_wb:** all `wb*` fields keep their value.
  3. **stall_mem:** all `wb*` fields go to 0 (bubble).
  4. **Otherwise:** all `wb*` fields load the corresponding `mem*` inputs.
- Reset values: every `wb*` output is 0, `hold_active` is 0, and the hold register is 0.
- Zeroed slot semantics: `wreg` = 0, `whilo` = 00 and `mreg` = 0, so a zeroed slot has no architectural effect.
- Hold buffer state machine, with `HOLD_EN` = 1 and states IDLE and HOLD:
  - **IDLE → HOLD:** when `stall_wb` && `wb0_valid` && `wb0_mreg` && !`flush`. At that edge, `hold_reg` ← `dm_rdata`.
  - **HOLD → HOLD:** while `stall_wb` && !`flush`. `hold_reg` is unchanged.
  - **HOLD → IDLE:** when !`stall_wb` or `flush`.
  - Reset state is IDLE.
- Output mux: `dm_o` = (state == HOLD) ? `hold_reg` : `dm_rdata`. `hold_active` = (state == HOLD).
- With `HOLD_EN` = 0, the FSM is tied to IDLE.
- Slot 1 never uses `dm_o`; `wb1_mreg` is passed through unchanged.

## Timing
- Latency is one cycle from the MEM inputs to the `wb*` outputs.
- `dm_o` path:
  - Combinational from `dm_rdata` in the first WB cycle of a load.
  - Registered from the second stalled cycle onward.
- The state, the registers and all outputs respond to `sys_rst_n` = 0 immediately, without waiting for a clock edge.
- Simultaneous `flush` and `stall_wb`: flush wins; slots clear and the FSM goes to IDLE.
- Simultaneous `stall_mem` and `stall_wb`: the WB registers hold and no bubble is inserted.
- Multi-cycle stall: `dm_o` equals the value `dm_rdata` had at the end of the first WB cycle, for the whole stall.
- Back-to-back loads with no stall: the FSM stays IDLE and `dm_o` tracks `dm_rdata` each cycle.
- Reset deasserted mid-stall: the block starts from IDLE with zeroed slots.

## Structure
- Shared package/defines: reuse `BSEL_BUS`, `REG_ADDR_BUS`, `DOUBLE_REG_BUS`, `REG_BUS`, `WORD_BUS` and `RST_ENABLE`; add the `HOLD_IDLE`/`HOLD_HOLD` state encodings.
- One natural sub-module, `memwb_slot`: a single slot's field register with flush/stall/bubble control, instantiated twice.
- The hold FSM and the `dm_o` mux live in the top module.

## Test plan
- **Reset:** `sys_rst_n` = 0 mid-cycle with nonzero inputs → all `wb*` outputs 0 and `hold_active` = 0 immediately.
- **Normal advance:** slot0 `wa` = 5, `dreg` = 0x1234, `wreg` = 1; slot1 `wa` = 7 → the next edge shows `wb0_wa` = 5, `wb0_dreg` = 0x1234 and `wb1_wa` = 7.
- **Bubble:**
  - Stimulus: `stall_mem` = 1, `stall_wb` = 0 for one cycle.
  - Required response: the next edge shows `wb0_wreg` = `wb1_wreg` = 0 and `wb0_whilo` = 00.
- **Load hold:**
  - Stimulus: load in slot0 reaches WB with `dm_rdata` = 0xDEADBEEF; `stall_wb` = 1 for 3 cycles while `dm_rdata` changes to 0x0.
  - Required response: `dm_o` = 0xDEADBEEF throughout and `hold_active` = 1 from the second cycle.
  - After release: `hold_active` = 0 and `dm_o` follows `dm_rdata`.
- **Flush vs stall:** `flush` = 1 and `stall_wb` = 1 together while in HOLD → `wb*` cleared, FSM in IDLE and `dm_o` = `dm_rdata`.
- **HOLD_EN = 0:** the load-hold stimulus above → `dm_o` tracks `dm_rdata` (0x0) and `hold_active` stays 0.

Source files
------------

// File: rtl/memwb_reg_pkg.sv
// Shared widths, hold-buffer state encoding and the slot field bundle for the
// dual-issue MEM/WB pipeline register.
package memwb_reg_pkg;

  localparam int BSEL_BUS       = 4;
  localparam int REG_ADDR_BUS   = 5;
  localparam int DOUBLE_REG_BUS = 64;
  localparam int REG_BUS        = 32;
  localparam int WORD_BUS       = 32;
  localparam int MEMTYPE_BUS    = 8;

  localparam logic RST_ENABLE = 1'b0;

  typedef enum logic {
    HOLD_IDLE = 1'b0,
    HOLD_HOLD = 1'b1
  } hold_state_e;

  typedef enum logic [1:0] {
    SLOT_CLEAR,
    SLOT_KEEP,
    SLOT_LOAD
  } slot_op_e;

  typedef struct packed {
    logic                      valid;
    logic [MEMTYPE_BUS-1:0]    memtype;
    logic                      mreg;
    logic [1:0]                whilo;
    logic                      wreg;
    logic [BSEL_BUS-1:0]       dre;
    logic [REG_ADDR_BUS-1:0]   wa;
    logic [DOUBLE_REG_BUS-1:0] hilo;
    logic [REG_BUS-1:0]        dreg;
    logic [1:0]                is_mthilo;
    logic [WORD_BUS-1:0]       daddr;
  } slot_t;

  // Flush beats a WB stall, which beats a MEM-stall bubble.
  function automatic slot_op_e slot_op(input logic flush, input logic stall_wb,
                                       input logic stall_mem);
    if (flush)          return SLOT_CLEAR;
    else if (stall_wb)  return SLOT_KEEP;
    else if (stall_mem) return SLOT_CLEAR;
    else                return SLOT_LOAD;
  endfunction

endpackage

// File: rtl/memwb_slot.sv
// One issue slot of the MEM/WB register: every field cleared, kept or loaded
// together according to flush/stall priority.
module memwb_slot
  import memwb_reg_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  flush,
  input  logic  stall_wb,
  input  logic  stall_mem,
  input  slot_t d,
  output slot_t q
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n == RST_ENABLE) begin
      q <= '0;
    end else begin
      unique case (slot_op(flush, stall_wb, stall_mem))
        SLOT_CLEAR: q <= '0;
        SLOT_KEEP:  q <= q;
        default:    q <= d;
      endcase
    end
  end

endmodule

// File: rtl/memwb_reg.sv
// Dual-issue MEM/WB pipeline register with a load-data hold buffer that keeps
// dm_o stable while WB is stalled on a slot-0 load.
module memwb_reg
  import memwb_reg_pkg::*;
#(
  parameter bit HOLD_EN = 1'b1
) (
  input  logic                      cpu_clk_50M,
  input  logic                      sys_rst_n,
  input  logic                      flush,
  input  logic                      stall_mem,
  input  logic                      stall_wb,

  input  logic                      mem0_valid,
  input  logic [MEMTYPE_BUS-1:0]    mem0_memtype,
  input  logic                      mem0_mreg,
  input  logic [1:0]                mem0_whilo,
  input  logic                      mem0_wreg,
  input  logic [BSEL_BUS-1:0]       mem0_dre,
  input  logic [REG_ADDR_BUS-1:0]   mem0_wa,
  input  logic [DOUBLE_REG_BUS-1:0] mem0_hilo,
  input  logic [REG_BUS-1:0]        mem0_dreg,
  input  logic [1:0]                mem0_is_mthilo,
  input  logic [WORD_BUS-1:0]       mem0_daddr,

  input  logic                      mem1_valid,
  input  logic [MEMTYPE_BUS-1:0]    mem1_memtype,
  input  logic                      mem1_mreg,
  input  logic [1:0]                mem1_whilo,
  input  logic                      mem1_wreg,
  input  logic [BSEL_BUS-1:0]       mem1_dre,
  input  logic [REG_ADDR_BUS-1:0]   mem1_wa,
  input  logic [DOUBLE_REG_BUS-1:0] mem1_hilo,
  input  logic [REG_BUS-1:0]        mem1_dreg,
  input  logic [1:0]                mem1_is_mthilo,
  input  logic [WORD_BUS-1:0]       mem1_daddr,

  input  logic [WORD_BUS-1:0]       dm_rdata,

  output logic                      wb0_valid,
  output logic [MEMTYPE_BUS-1:0]    wb0_memtype,
  output logic                      wb0_mreg,
  output logic [1:0]                wb0_whilo,
  output logic                      wb0_wreg,
  output logic [BSEL_BUS-1:0]       wb0_dre,
  output logic [REG_ADDR_BUS-1:0]   wb0_wa,
  output logic [DOUBLE_REG_BUS-1:0] wb0_hilo,
  output logic [REG_BUS-1:0]        wb0_dreg,
  output logic [1:0]                wb0_is_mthilo,
  output logic [WORD_BUS-1:0]       wb0_daddr,

  output logic                      wb1_valid,
  output logic [MEMTYPE_BUS-1:0]    wb1_memtype,
  output logic                      wb1_mreg,
  output logic [1:0]                wb1_whilo,
  output logic                      wb1_wreg,
  output logic [BSEL_BUS-1:0]       wb1_dre,
  output logic [REG_ADDR_BUS-1:0]   wb1_wa,
  output logic [DOUBLE_REG_BUS-1:0] wb1_hilo,
  output logic [REG_BUS-1:0]        wb1_dreg,
  output logic [1:0]                wb1_is_mthilo,
  output logic [WORD_BUS-1:0]       wb1_daddr,

  output logic [WORD_BUS-1:0]       dm_o,
  output logic                      hold_active
);

  slot_t d0, d1, q0, q1;

  assign d0 = '{valid: mem0_valid, memtype: mem0_memtype, mreg: mem0_mreg,
                whilo: mem0_whilo, wreg: mem0_wreg, dre: mem0_dre, wa: mem0_wa,
                hilo: mem0_hilo, dreg: mem0_dreg, is_mthilo: mem0_is_mthilo,
                daddr: mem0_daddr};
  assign d1 = '{valid: mem1_valid, memtype: mem1_memtype, mreg: mem1_mreg,
                whilo: mem1_whilo, wreg: mem1_wreg, dre: mem1_dre, wa: mem1_wa,
                hilo: mem1_hilo, dreg: mem1_dreg, is_mthilo: mem1_is_mthilo,
                daddr: mem1_daddr};

  memwb_slot u_slot0 (
    .clk       (cpu_clk_50M),
    .rst_n     (sys_rst_n),
    .flush     (flush),
    .stall_wb  (stall_wb),
    .stall_mem (stall_mem),
    .d         (d0),
    .q         (q0)
  );

  memwb_slot u_slot1 (
    .clk       (cpu_clk_50M),
    .rst_n     (sys_rst_n),
    .flush     (flush),
    .stall_wb  (stall_wb),
    .stall_mem (stall_mem),
    .d         (d1),
    .q         (q1)
  );

  assign wb0_valid     = q0.valid;
  assign wb0_memtype   = q0.memtype;
  assign wb0_mreg      = q0.mreg;
  assign wb0_whilo     = q0.whilo;
  assign wb0_wreg      = q0.wreg;
  assign wb0_dre       = q0.dre;
  assign wb0_wa        = q0.wa;
  assign wb0_hilo      = q0.hilo;
  assign wb0_dreg      = q0.dreg;
  assign wb0_is_mthilo = q0.is_mthilo;
  assign wb0_daddr     = q0.daddr;

  assign wb1_valid     = q1.valid;
  assign wb1_memtype   = q1.memtype;
  assign wb1_mreg      = q1.mreg;
  assign wb1_whilo     = q1.whilo;
  assign wb1_wreg      = q1.wreg;
  assign wb1_dre       = q1.dre;
  assign wb1_wa        = q1.wa;
  assign wb1_hilo      = q1.hilo;
  assign wb1_dreg      = q1.dreg;
  assign wb1_is_mthilo = q1.is_mthilo;
  assign wb1_daddr     = q1.daddr;

  hold_state_e         state, state_next;
  logic                capture;
  logic [WORD_BUS-1:0] hold_reg;

  always_ff @(posedge cpu_clk_50M or negedge sys_rst_n) begin
    if (sys_rst_n == RST_ENABLE) state <= HOLD_IDLE;
    else                         state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and infers a latch.
  always_comb begin
    state_next = HOLD_IDLE;
    capture    = 1'b0;
    if (HOLD_EN) begin
      unique case (state)
        HOLD_IDLE: begin
          if (stall_wb && q0.valid && q0.mreg && !flush) begin
            state_next = HOLD_HOLD;
            capture    = 1'b1;
          end
        end
        HOLD_HOLD: begin
          if (stall_wb && !flush) state_next = HOLD_HOLD;
        end
        default: state_next = HOLD_IDLE;
      endcase
    end
  end

  // The RAM output is still valid at the end of the first WB cycle; grab it
  // there because it may change once the stall continues.
  always_ff @(posedge cpu_clk_50M or negedge sys_rst_n) begin
    if (sys_rst_n == RST_ENABLE) hold_reg <= '0;
    else if (capture)            hold_reg <= dm_rdata;
  end

  assign hold_active = (state == HOLD_HOLD);
  assign dm_o        = hold_active ? hold_reg : dm_rdata;

endmodule

// File: tb/tb_memwb_reg.sv
// Directed-vector bench for memwb_reg: the driver queues hand-computed
// expectations per cycle and a negedge monitor pops and compares them.
module tb_memwb_reg;
  import memwb_reg_pkg::*;

  typedef struct packed {
    logic        valid;
    logic        mreg;
    logic        wreg;
    logic [1:0]  whilo;
    logic [4:0]  wa;
    logic [31:0] dreg;
  } vec_t;

  typedef struct {
    int          tag;
    string       name;
    slot_t       w0;
    slot_t       w1;
    logic [31:0] dm;
    logic        hold;
    logic [31:0] dm_n;
    logic        hold_n;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0, stall_mem = 1'b0, stall_wb = 1'b0;
  slot_t       s0 = '0, s1 = '0;
  logic [31:0] dm_rdata = '0;

  wire slot_t  w0, w1, w0_n, w1_n;
  wire [31:0]  dm_o, dm_o_n;
  wire         hold_active, hold_active_n;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  memwb_reg #(.HOLD_EN(1'b1)) dut (
    .cpu_clk_50M(clk), .sys_rst_n(rst_n), .flush(flush),
    .stall_mem(stall_mem), .stall_wb(stall_wb),
    .mem0_valid(s0.valid), .mem0_memtype(s0.memtype), .mem0_mreg(s0.mreg),
    .mem0_whilo(s0.whilo), .mem0_wreg(s0.wreg), .mem0_dre(s0.dre),
    .mem0_wa(s0.wa), .mem0_hilo(s0.hilo), .mem0_dreg(s0.dreg),
    .mem0_is_mthilo(s0.is_mthilo), .mem0_daddr(s0.daddr),
    .mem1_valid(s1.valid), .mem1_memtype(s1.memtype), .mem1_mreg(s1.mreg),
    .mem1_whilo(s1.whilo), .mem1_wreg(s1.wreg), .mem1_dre(s1.dre),
    .mem1_wa(s1.wa), .mem1_hilo(s1.hilo), .mem1_dreg(s1.dreg),
    .mem1_is_mthilo(s1.is_mthilo), .mem1_daddr(s1.daddr),
    .dm_rdata(dm_rdata),
    .wb0_valid(w0.valid), .wb0_memtype(w0.memtype), .wb0_mreg(w0.mreg),
    .wb0_whilo(w0.whilo), .wb0_wreg(w0.wreg), .wb0_dre(w0.dre),
    .wb0_wa(w0.wa), .wb0_hilo(w0.hilo), .wb0_dreg(w0.dreg),
    .wb0_is_mthilo(w0.is_mthilo), .wb0_daddr(w0.daddr),
    .wb1_valid(w1.valid), .wb1_memtype(w1.memtype), .wb1_mreg(w1.mreg),
    .wb1_whilo(w1.whilo), .wb1_wreg(w1.wreg), .wb1_dre(w1.dre),
    .wb1_wa(w1.wa), .wb1_hilo(w1.hilo), .wb1_dreg(w1.dreg),
    .wb1_is_mthilo(w1.is_mthilo), .wb1_daddr(w1.daddr),
    .dm_o(dm_o), .hold_active(hold_active)
  );

  memwb_reg #(.HOLD_EN(1'b0)) dut_n (
    .cpu_clk_50M(clk), .sys_rst_n(rst_n), .flush(flush),
    .stall_mem(stall_mem), .stall_wb(stall_wb),
    .mem0_valid(s0.valid), .mem0_memtype(s0.memtype), .mem0_mreg(s0.mreg),
    .mem0_whilo(s0.whilo), .mem0_wreg(s0.wreg), .mem0_dre(s0.dre),
    .mem0_wa(s0.wa), .mem0_hilo(s0.hilo), .mem0_dreg(s0.dreg),
    .mem0_is_mthilo(s0.is_mthilo), .mem0_daddr(s0.daddr),
    .mem1_valid(s1.valid), .mem1_memtype(s1.memtype), .mem1_mreg(s1.mreg),
    .mem1_whilo(s1.whilo), .mem1_wreg(s1.wreg), .mem1_dre(s1.dre),
    .mem1_wa(s1.wa), .mem1_hilo(s1.hilo), .mem1_dreg(s1.dreg),
    .mem1_is_mthilo(s1.is_mthilo), .mem1_daddr(s1.daddr),
    .dm_rdata(dm_rdata),
    .wb0_valid(w0_n.valid), .wb0_memtype(w0_n.memtype), .wb0_mreg(w0_n.mreg),
    .wb0_whilo(w0_n.whilo), .wb0_wreg(w0_n.wreg), .wb0_dre(w0_n.dre),
    .wb0_wa(w0_n.wa), .wb0_hilo(w0_n.hilo), .wb0_dreg(w0_n.dreg),
    .wb0_is_mthilo(w0_n.is_mthilo), .wb0_daddr(w0_n.daddr),
    .wb1_valid(w1_n.valid), .wb1_memtype(w1_n.memtype), .wb1_mreg(w1_n.mreg),
    .wb1_whilo(w1_n.whilo), .wb1_wreg(w1_n.wreg), .wb1_dre(w1_n.dre),
    .wb1_wa(w1_n.wa), .wb1_hilo(w1_n.hilo), .wb1_dreg(w1_n.dreg),
    .wb1_is_mthilo(w1_n.is_mthilo), .wb1_daddr(w1_n.daddr),
    .dm_o(dm_o_n), .hold_active(hold_active_n)
  );

  function automatic vec_t vec(input logic valid, input logic mreg,
                               input logic wreg, input logic [1:0] whilo,
                               input logic [4:0] wa, input logic [31:0] dreg);
    return '{valid: valid, mreg: mreg, wreg: wreg, whilo: whilo, wa: wa, dreg: dreg};
  endfunction

  // Fills the remaining fields from the directed ones; an all-zero vector
  // expands to an all-zero slot.
  function automatic slot_t expand(input vec_t v);
    slot_t s;
    s.valid     = v.valid;
    s.memtype   = v.mreg ? 8'h05 : 8'h00;
    s.mreg      = v.mreg;
    s.whilo     = v.whilo;
    s.wreg      = v.wreg;
    s.dre       = v.mreg ? 4'hF : 4'h0;
    s.wa        = v.wa;
    s.hilo      = {v.dreg, v.dreg[15:0], v.dreg[31:16]};
    s.dreg      = v.dreg;
    s.is_mthilo = v.whilo;
    s.daddr     = {v.dreg[15:0], v.dreg[31:16]};
    return s;
  endfunction

  task automatic check(input exp_t e);
    n_checks++;
    if ({w0, w1, dm_o, hold_active, dm_o_n, hold_active_n} !==
        {e.w0, e.w1, e.dm, e.hold, e.dm_n, e.hold_n}) begin
      n_fail++;
      $display("FAIL %s: got wb0=%h wb1=%h dm_o=%h hold=%b dm_o_n=%h hold_n=%b; exp wb0=%h wb1=%h dm_o=%h hold=%b dm_o_n=%h hold_n=%b",
               e.name, w0, w1, dm_o, hold_active, dm_o_n, hold_active_n,
               e.w0, e.w1, e.dm, e.hold, e.dm_n, e.hold_n);
    end
  endtask

  // One cycle of stimulus plus the outputs expected during that same cycle.
  task automatic row(input string name, input logic rst, input logic fl,
                     input logic sm, input logic sw, input vec_t i0, input vec_t i1,
                     input logic [31:0] dm, input vec_t e0, input vec_t e1,
                     input logic [31:0] edm, input logic ehold);
    exp_t e;
    @(posedge clk);
    #2;
    rst_n     = rst;
    flush     = fl;
    stall_mem = sm;
    stall_wb  = sw;
    s0        = expand(i0);
    s1        = expand(i1);
    dm_rdata  = dm;
    e.tag    = cyc;
    e.name   = name;
    e.w0     = expand(e0);
    e.w1     = expand(e1);
    e.dm     = edm;
    e.hold   = ehold;
    e.dm_n   = dm;
    e.hold_n = 1'b0;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].tag <= cyc) begin
        e = sb.pop_front();
        if (e.tag < cyc) begin
          n_checks++;
          n_fail++;
          $display("FAIL %s: sampled in cycle %0d, required cycle %0d", e.name, cyc, e.tag);
        end else begin
          check(e);
        end
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: run still active at %0t, required completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    vec_t z, a0, a1, b0, b1, l0, l1, c0, l2, l21, d0, l3, l4, l5, e0;
    z   = '0;
    a0  = vec(1, 0, 1, 2'b00, 5'd5,  32'h0000_1234);
    a1  = vec(1, 0, 1, 2'b00, 5'd7,  32'h0000_0055);
    b0  = vec(1, 0, 1, 2'b11, 5'd9,  32'h0000_0999);
    b1  = vec(1, 0, 1, 2'b10, 5'd11, 32'h0000_0066);
    l0  = vec(1, 1, 1, 2'b00, 5'd3,  32'h0000_0100);
    l1  = vec(1, 0, 1, 2'b00, 5'd8,  32'h0000_0088);
    c0  = vec(1, 0, 1, 2'b00, 5'd12, 32'h0000_0777);
    l2  = vec(1, 1, 1, 2'b00, 5'd4,  32'h0000_0200);
    l21 = vec(1, 0, 1, 2'b01, 5'd9,  32'h0000_0099);
    d0  = vec(1, 0, 1, 2'b00, 5'd1,  32'h0000_0001);
    l3  = vec(1, 1, 1, 2'b00, 5'd6,  32'h0000_0300);
    l4  = vec(1, 1, 1, 2'b00, 5'd7,  32'h0000_0301);
    l5  = vec(1, 1, 1, 2'b00, 5'd10, 32'h0000_0400);
    e0  = vec(1, 0, 1, 2'b00, 5'd2,  32'h0000_0009);

    //   name                rst fl sm sw  in0 in1  dm_rdata      exp0 exp1 dm_o        hold
    row("reset_state",        0, 0, 0, 0, a0, a1,  32'h0,        z,   z,   32'h0,        0);
    row("reset_release",      1, 0, 0, 0, a0, a1,  32'h0,        z,   z,   32'h0,        0);
    row("normal_advance",     1, 0, 1, 0, b0, b1,  32'h11,       a0,  a1,  32'h11,       0);
    row("bubble",             1, 0, 0, 0, l0, l1,  32'h0,        z,   z,   32'h0,        0);
    row("load_first_wb",      1, 0, 0, 1, c0, z,   32'hDEADBEEF, l0,  l1,  32'hDEADBEEF, 0);
    row("load_hold_2",        1, 0, 0, 1, c0, z,   32'h0,        l0,  l1,  32'hDEADBEEF, 1);
    row("load_hold_3",        1, 0, 0, 1, c0, z,   32'h0,        l0,  l1,  32'hDEADBEEF, 1);
    row("load_release",       1, 0, 0, 0, c0, z,   32'h0,        l0,  l1,  32'hDEADBEEF, 1);
    row("after_release",      1, 0, 0, 0, l2, l21, 32'hCAFE0001, c0,  z,   32'hCAFE0001, 0);
    row("load2_first_wb",     1, 0, 0, 1, d0, d0,  32'hA5A5A5A5, l2,  l21, 32'hA5A5A5A5, 0);
    row("load2_hold",         1, 0, 0, 1, d0, d0,  32'h1,        l2,  l21, 32'hA5A5A5A5, 1);
    row("flush_with_stall",   1, 1, 0, 1, d0, d0,  32'h2,        l2,  l21, 32'hA5A5A5A5, 1);
    row("flush_result",       1, 0, 0, 1, d0, d0,  32'h3,        z,   z,   32'h3,        0);
    row("stall_empty_slot",   1, 0, 0, 1, d0, d0,  32'h4,        z,   z,   32'h4,        0);
    row("b2b_load_a",         1, 0, 0, 0, l3, z,   32'h5,        z,   z,   32'h5,        0);
    row("b2b_load_b",         1, 0, 0, 0, l4, z,   32'h6,        l3,  z,   32'h6,        0);
    row("dual_stall",         1, 0, 1, 1, z,  z,   32'h7,        l4,  z,   32'h7,        0);
    row("dual_stall_hold",    1, 0, 0, 0, z,  z,   32'h8,        l4,  z,   32'h7,        1);
    row("dual_stall_release", 1, 0, 0, 0, l5, z,   32'h9,        z,   z,   32'h9,        0);
    row("rst_load_first",     1, 0, 0, 1, d0, z,   32'hB,        l5,  z,   32'hB,        0);
    row("rst_load_hold",      1, 0, 0, 1, d0, z,   32'hC,        l5,  z,   32'hB,        1);
    row("reset_mid_stall",    0, 0, 0, 1, l5, l1,  32'hD,        z,   z,   32'hD,        0);
    row("reset_release_stall",1, 0, 0, 1, e0, z,   32'hE,        z,   z,   32'hE,        0);
    row("post_reset_stall",   1, 0, 0, 0, e0, z,   32'hF,        z,   z,   32'hF,        0);
    row("post_reset_advance", 1, 0, 0, 0, z,  z,   32'h10,       e0,  z,   32'h10,       0);

    repeat (2) @(posedge clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: never sampled, required in cycle %0d", e.name, e.tag);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
